// File: rtl/rca4_serial_ctrl.sv
// -----------------------------------------------------------------------------
// rca4_serial_ctrl
//
// Nibble-serial sequencer and round-robin arbiter for a shared external 4-bit
// ripple-carry adder. Two requesters submit wide add/subtract jobs. The block
// feeds the adder one nibble per clock, least-significant nibble first. The
// carry is threaded through a register. The block returns the wide result with
// its carry and two's-complement overflow flags.
//
// Ports
//   Clk, Rst_b            clock, asynchronous active-low reset
//   Req0/Req1             job requests (held until the matching Gnt)
//   X0/Y0/Sub0, X1/Y1/Sub1 operands and op select per requester (1 = X-Y)
//   Gnt0/Gnt1             one-cycle acceptance pulses
//   AdderA/AdderB/AdderCin nibble operands and carry-in driven to the adder
//   AdderSum/AdderCout    combinational sum/carry returned from the adder
//   Result/CarryOut/Overflow/DoneId  completed-job outputs, held until next Done
//   Done                  one-cycle completion pulse
// -----------------------------------------------------------------------------
module rca4_serial_ctrl #(
   parameter int NIBBLES = 4
) (
   input  logic                   Clk,
   input  logic                   Rst_b,
   input  logic                   Req0,
   input  logic                   Req1,
   input  logic [4*NIBBLES-1:0]   X0,
   input  logic [4*NIBBLES-1:0]   Y0,
   input  logic [4*NIBBLES-1:0]   X1,
   input  logic [4*NIBBLES-1:0]   Y1,
   input  logic                   Sub0,
   input  logic                   Sub1,
   output logic                   Gnt0,
   output logic                   Gnt1,
   output logic [3:0]             AdderA,
   output logic [3:0]             AdderB,
   output logic                   AdderCin,
   input  logic [3:0]             AdderSum,
   input  logic                   AdderCout,
   output logic [4*NIBBLES-1:0]   Result,
   output logic                   CarryOut,
   output logic                   Overflow,
   output logic                   Done,
   output logic                   DoneId
);

   localparam int W  = 4 * NIBBLES;
   localparam int KW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
   localparam logic [KW-1:0] K_LAST = KW'(NIBBLES - 1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]    r_state;
   logic [KW-1:0] r_k;
   logic          r_carry;
   logic          r_last_id;
   logic [W-1:0]  r_op_a;
   logic [W-1:0]  r_op_b;
   logic [W-1:0]  r_result;
   logic          r_carry_out;
   logic          r_overflow;
   logic          r_done_id;
   logic          r_gnt0;
   logic          r_gnt1;

   logic          w_any_req;
   logic          w_pick1;
   logic          w_sel_sub;
   logic [W-1:0]  w_sel_x;
   logic [W-1:0]  w_sel_y;
   logic          w_run;
   logic          w_last_nib;
   logic [3:0]    w_a_nib [NIBBLES];
   logic [3:0]    w_b_nib [NIBBLES];

   // Split the latched operands into nibble lanes so the adder feed is a
   // simple mux indexed by the nibble counter.
   genvar gi;
   generate
      for (gi = 0; gi < NIBBLES; gi++) begin : g_nib
         assign w_a_nib[gi] = r_op_a[4*gi +: 4];
         assign w_b_nib[gi] = r_op_b[4*gi +: 4];
      end
   endgenerate

   // Round-robin: on a tie the requester that was not served last wins.
   // LastId resets to 1 so Req0 wins the first tie after reset.
   assign w_any_req = Req0 | Req1;
   assign w_pick1   = Req1 & (~Req0 | ~r_last_id);
   assign w_sel_sub = w_pick1 ? Sub1 : Sub0;
   assign w_sel_x   = w_pick1 ? X1 : X0;
   assign w_sel_y   = w_pick1 ? Y1 : Y0;

   assign w_run      = (r_state == S_RUN);
   assign w_last_nib = (r_k == K_LAST);

   always_ff @(posedge Clk or negedge Rst_b) begin
      if (!Rst_b) begin
         r_state     <= S_IDLE;
         r_k         <= '0;
         r_carry     <= 1'b0;
         r_last_id   <= 1'b1;
         r_op_a      <= '0;
         r_op_b      <= '0;
         r_result    <= '0;
         r_carry_out <= 1'b0;
         r_overflow  <= 1'b0;
         r_done_id   <= 1'b0;
         r_gnt0      <= 1'b0;
         r_gnt1      <= 1'b0;
      end else begin
         r_gnt0 <= 1'b0;
         r_gnt1 <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_any_req) begin
                  r_state   <= S_RUN;
                  r_op_a    <= w_sel_x;
                  // Subtract is X + ~Y + 1: the +1 enters as the initial carry.
                  r_op_b    <= w_sel_sub ? ~w_sel_y : w_sel_y;
                  r_carry   <= w_sel_sub;
                  r_k       <= '0;
                  r_last_id <= w_pick1;
                  r_gnt0    <= ~w_pick1;
                  r_gnt1    <= w_pick1;
               end
            end
            S_RUN: begin
               r_result[4*r_k +: 4] <= AdderSum;
               r_carry              <= AdderCout;
               r_k                  <= r_k + 1'b1;
               if (w_last_nib) begin
                  r_state     <= S_DONE;
                  r_k         <= '0;
                  r_carry_out <= AdderCout;
                  // The result MSB is the top bit of the nibble being written now.
                  r_overflow  <= (r_op_a[W-1] == r_op_b[W-1]) &&
                                 (AdderSum[3] != r_op_a[W-1]);
                  r_done_id   <= r_last_id;
               end
            end
            S_DONE: begin
               r_state <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   // Adder inputs are forced to zero outside RUN so the shared adder idles.
   assign AdderA   = w_run ? w_a_nib[r_k] : 4'd0;
   assign AdderB   = w_run ? w_b_nib[r_k] : 4'd0;
   assign AdderCin = w_run & r_carry;

   assign Gnt0     = r_gnt0;
   assign Gnt1     = r_gnt1;
   assign Done     = (r_state == S_DONE);
   assign Result   = r_result;
   assign CarryOut = r_carry_out;
   assign Overflow = r_overflow;
   assign DoneId   = r_done_id;

endmodule
